// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: blanking patterns,
// hex segment table ({g..a}, active-low) and scan FSM state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit common-anode scan controller with tear-free frame commit.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic [7:0]          wr_data,
    output logic                wr_ready,
    input  logic                clr,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                frame
);

    localparam int SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int DW = 4 * N_DIGITS;

    logic [SW-1:0]       slot_cnt, slot_nxt;
    logic [IW-1:0]       idx;
    logic                slot_wrap, idx_wrap, boundary;
    scan_state_e         state_q, state_d;
    logic [DW-1:0]       shadow, shadow_nxt, disp;
    logic                pending, xfer;
    logic [3:0]          nib;
    logic [6:0]          lut_seg, seg_d;
    logic [N_DIGITS-1:0] an_d;
    logic                lz_blank;

    assign slot_wrap = (slot_cnt == SW'(SLOT_CYC - 1));
    assign idx_wrap  = (idx == IW'(N_DIGITS - 1));
    assign boundary  = slot_wrap && idx_wrap;
    assign slot_nxt  = slot_wrap ? '0 : slot_cnt + 1'b1;
    assign xfer      = wr_valid && wr_ready;
    assign shadow_nxt = xfer ? ((shadow << 8) | DW'(wr_data)) : shadow;
    assign nib       = disp[{idx, 2'b00} +: 4];

    seg7_hex_lut u_lut (
        .nib (nib),
        .seg (lut_seg)
    );

`ifdef SEG7_LZB_EN
    // Dark when this nibble and every more-significant one is zero; digit 0 always lit.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) >= idx && disp[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        lz_blank = upper_zero && (idx != '0);
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        state_d = (slot_nxt < SW'(BLANK_CYC)) ? BLANK : SHOW;
        an_d    = AN_OFF[N_DIGITS-1:0];
        seg_d   = SEG_OFF;
        if (state_q == SHOW) begin
            an_d[idx] = 1'b0;
            seg_d     = lz_blank ? SEG_OFF : lut_seg;
        end
    end

    // Scan timing and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
            state_q  <= BLANK;
            seg      <= SEG_OFF;
            an       <= AN_OFF[N_DIGITS-1:0];
            frame    <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            slot_cnt <= slot_nxt;
            if (slot_wrap)
                idx <= idx_wrap ? '0 : idx + 1'b1;
            state_q  <= state_d;
            seg      <= seg_d;
            an       <= an_d;
            frame    <= boundary;
            wr_ready <= 1'b1;
        end
    end

    // Shadow buffer and frame-boundary commit; clr wins over write and commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else if (clr) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (boundary && (pending || xfer)) begin
                disp    <= shadow_nxt;
                pending <= 1'b0;
            end else if (xfer) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
